// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings carried on req_size
//   - FSM state encoding used by lsu
//   - is_misaligned(): alignment / reserved-size check for a request
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_LOAD   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // A request is rejected when its size is reserved or its byte offset
    // is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane steering for the load/store unit.
// Ports:
//   st_size, st_offset, st_wdata -> st_we (byte enables), st_lanes (replicated data)
//   ld_size, ld_offset, ld_signed, ld_rdata -> ld_data (extracted, extended word)
// Store and load sides are independent so the top can feed the store side
// from the live request and the load side from latched request fields.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_we,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store: replicate the right-justified datum over every lane it could
    // land in; the byte enables pick the lane(s) actually written.
    always_comb begin
        st_we    = 4'b0000;
        st_lanes = st_wdata;
        case (st_size)
            SIZE_BYTE: begin
                st_lanes = {4{st_wdata[7:0]}};
                st_we    = 4'b0001 << st_offset;
            end
            SIZE_HALF: begin
                st_lanes = {2{st_wdata[15:0]}};
                st_we    = 4'b0011 << st_offset;
            end
            SIZE_WORD: begin
                st_we    = 4'b1111;
            end
            default: begin
                st_we    = 4'b0000;
            end
        endcase
    end

    // Load: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = ld_rdata >> {ld_offset, 3'b000};
        ld_data = 32'd0;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: ld_data = ld_rdata;
            default:   ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit in front of port A of the data RAM.
// Ports:
//   clk, reset (async, active-low)
//   req_*  : one load/store per valid/ready handshake, byte address
//   resp_* : extended load data + error flag, held until resp_ready
//   ram_*  : word address, byte enables, lane data to RAM; ram_rdata is the
//            registered read port (valid the cycle after address sampling)
// Sequence: IDLE -> ACCESS -> (LOAD) -> RESP -> IDLE; misaligned or
// reserved-size requests go IDLE -> RESP with the error flag and never
// touch the RAM.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_t state_reg, state_next;

    logic [3:0]            ram_we_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [DATA_WIDTH-1:0] ram_wdata_reg;
    logic [DATA_WIDTH-1:0] resp_rdata_reg;
    logic                  resp_error_reg;
    logic                  write_reg;
    logic                  signed_reg;
    logic [1:0]            size_reg;
    logic [1:0]            offset_reg;

    logic                  req_bad;
    logic [3:0]            st_we;
    logic [31:0]           st_lanes;
    logic [31:0]           ld_data;

    assign req_bad = is_misaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .st_size   (req_size),
        .st_offset (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_we     (st_we),
        .st_lanes  (st_lanes),
        .ld_size   (size_reg),
        .ld_offset (offset_reg),
        .ld_signed (signed_reg),
        .ld_rdata  (ram_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = req_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = write_reg ? ST_RESP : ST_LOAD;
            ST_LOAD:   state_next = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_we_reg     <= 4'b0000;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            resp_rdata_reg <= '0;
            resp_error_reg <= 1'b0;
            write_reg      <= 1'b0;
            signed_reg     <= 1'b0;
            size_reg       <= SIZE_BYTE;
            offset_reg     <= 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            resp_error_reg <= 1'b1;
                            resp_rdata_reg <= '0;
                        end else begin
                            ram_addr_reg  <= req_addr[ADDR_WIDTH+1:2];
                            ram_we_reg    <= req_write ? st_we : 4'b0000;
                            ram_wdata_reg <= st_lanes;
                            write_reg     <= req_write;
                            signed_reg    <= req_signed;
                            size_reg      <= req_size;
                            offset_reg    <= req_addr[1:0];
                        end
                    end
                end
                // The RAM captures the write at the edge closing ACCESS, so
                // the enables must drop on that same edge.
                ST_ACCESS: ram_we_reg <= 4'b0000;
                ST_LOAD:   resp_rdata_reg <= ld_data;
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_error_reg <= 1'b0;
                        resp_rdata_reg <= '0;
                    end
                end
                default: ram_we_reg <= 4'b0000;
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_error = resp_error_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven check of lsu against a behavioural RAM with a
// registered read port, plus hand sequences for backpressure and reset
// during ACCESS.
module tb_lsu;

    localparam int AW = 9;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int n_cmp;
    int n_bad;

    lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM port A: byte-enabled write, registered read-before-write.
    logic [31:0]   mem [0:511];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        string       name;
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic write, logic [1:0] size, logic sgn,
                                logic [10:0] addr, logic [31:0] wdata, logic [31:0] exp_rdata,
                                logic exp_err, logic [3:0] exp_we, logic [31:0] exp_wdata);
        vec_t v;
        v.name = name; v.write = write; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_we = exp_we; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".req_ready"},  {31'd0, req_ready},  32'd1);
        chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".resp_error"}, {31'd0, resp_error}, 32'd0);
        chk({tag, ".resp_rdata"}, resp_rdata,          32'd0);
        chk({tag, ".ram_we"},     {28'd0, ram_we},     32'd0);
    endtask

    // Issue one request, check the RAM-side outputs during ACCESS, the
    // response latency and contents, optional backpressure, and the handshake.
    task automatic run_op(input vec_t v, input int hold);
        int cycles;
        int exp_lat;
        logic [31:0] first_rdata;
        exp_lat = v.exp_err ? 1 : (v.write ? 2 : 3);
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cycles = 1;
        chk({v.name, ".ram_we"}, {28'd0, ram_we}, {28'd0, v.exp_we});
        if (!v.exp_err) begin
            chk({v.name, ".ram_addr"}, {23'd0, ram_addr}, {23'd0, v.addr[10:2]});
            if (v.write) chk({v.name, ".ram_wdata"}, ram_wdata, v.exp_wdata);
        end
        while (!resp_valid && cycles < 10) begin
            @(negedge clk);
            cycles++;
            chk({v.name, ".ram_we_after"}, {28'd0, ram_we}, 32'd0);
        end
        chk({v.name, ".latency"}, cycles, exp_lat);
        chk({v.name, ".resp_rdata"}, resp_rdata, v.exp_rdata);
        chk({v.name, ".resp_error"}, {31'd0, resp_error}, {31'd0, v.exp_err});
        chk({v.name, ".req_ready_busy"}, {31'd0, req_ready}, 32'd0);
        first_rdata = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            // A competing store to word 0 must be ignored while busy.
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
            req_addr = 11'h000; req_wdata = 32'hFFFFFFFF;
            @(negedge clk);
            chk({v.name, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({v.name, ".hold_rdata"}, resp_rdata, first_rdata);
            chk({v.name, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
            chk({v.name, ".hold_we"}, {28'd0, ram_we}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check_idle_outputs({v.name, ".after"});
        $display("op %-10s addr=0x%03h lat=%0d rdata=0x%08h err=%0d", v.name, v.addr, cycles,
                 first_rdata, v.exp_err);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        preload(9'd0,  32'h11223344);
        preload(9'd4,  32'h00000000);
        preload(9'd8,  32'hAABBCCDD);
        preload(9'd16, 32'h00000000);

        check_idle_outputs("reset");
        chk("reset.ram_addr",  {23'd0, ram_addr}, 32'd0);
        chk("reset.ram_wdata", ram_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //          name        wr size sg addr    wdata          exp_rdata      err we      exp_wdata
        vecs.push_back(mk("sw10",  1, 2, 0, 11'h010, 32'hDEADBEEF, 32'h00000000, 0, 4'hF,    32'hDEADBEEF));
        vecs.push_back(mk("lw10",  0, 2, 1, 11'h010, 32'h0,        32'hDEADBEEF, 0, 4'h0,    32'h0));
        vecs.push_back(mk("sb13",  1, 0, 0, 11'h013, 32'hFFFFFF80, 32'h00000000, 0, 4'b1000, 32'h80808080));
        vecs.push_back(mk("lb13",  0, 0, 1, 11'h013, 32'h0,        32'hFFFFFF80, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lbu13", 0, 0, 0, 11'h013, 32'h0,        32'h00000080, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lbu12", 0, 0, 0, 11'h012, 32'h0,        32'h000000AD, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lb12",  0, 0, 1, 11'h012, 32'h0,        32'hFFFFFFAD, 0, 4'h0,    32'h0));
        vecs.push_back(mk("sh22",  1, 1, 0, 11'h022, 32'hFFFF1234, 32'h00000000, 0, 4'b1100, 32'h12341234));
        vecs.push_back(mk("lw20",  0, 2, 0, 11'h020, 32'h0,        32'h1234CCDD, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lh22",  0, 1, 1, 11'h022, 32'h0,        32'h00001234, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lh20",  0, 1, 1, 11'h020, 32'h0,        32'hFFFFCCDD, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lhu20", 0, 1, 0, 11'h020, 32'h0,        32'h0000CCDD, 0, 4'h0,    32'h0));
        vecs.push_back(mk("sb41",  1, 0, 0, 11'h041, 32'h000000A5, 32'h00000000, 0, 4'b0010, 32'hA5A5A5A5));
        vecs.push_back(mk("lw40",  0, 2, 0, 11'h040, 32'h0,        32'h0000A500, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lb41",  0, 0, 1, 11'h041, 32'h0,        32'hFFFFFFA5, 0, 4'h0,    32'h0));
        vecs.push_back(mk("lw21",  0, 2, 0, 11'h021, 32'h0,        32'h00000000, 1, 4'h0,    32'h0));
        vecs.push_back(mk("sh03",  1, 1, 0, 11'h003, 32'h0000FFFF, 32'h00000000, 1, 4'h0,    32'h0));
        vecs.push_back(mk("ld_sz3",0, 3, 0, 11'h000, 32'h0,        32'h00000000, 1, 4'h0,    32'h0));
        vecs.push_back(mk("st_sz3",1, 3, 0, 11'h004, 32'hFFFFFFFF, 32'h00000000, 1, 4'h0,    32'h0));

        foreach (vecs[i]) run_op(vecs[i], 0);

        // Backpressure: response held 5 cycles with a competing request.
        run_op(mk("lw10_bp", 0, 2, 0, 11'h010, 32'h0, 32'h80ADBEEF, 0, 4'h0, 32'h0), 5);
        // Next request accepted right after the handshake; word 0 untouched.
        run_op(mk("lw00_a", 0, 2, 0, 11'h000, 32'h0, 32'h11223344, 0, 4'h0, 32'h0), 0);

        // Reset asserted while a store sits in ACCESS.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 11'h000; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid.ram_we_access", {28'd0, ram_we}, 32'hF);
        #1 reset = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        chk("rst_mid.ram_addr",  {23'd0, ram_addr}, 32'd0);
        chk("rst_mid.ram_wdata", ram_wdata, 32'd0);
        $display("op rst_mid   reset asserted during ACCESS of sw 0xFFFFFFFF");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_op(mk("lw00_rst", 0, 2, 0, 11'h000, 32'h0, 32'h11223344, 0, 4'h0, 32'h0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
